// File: rtl/race_outcome_ctrl_if.sv
// Bundle of the screen/event inputs and the race outcome/HUD outputs
// exchanged between the race rules engine and its surroundings.
interface race_outcome_ctrl_if;
  logic [1:0] SCREEN;
  logic       COLLISION;
  logic       CHECKPOINT;
  logic       GAME_WIN;
  logic       GAME_LOSE;
  logic [6:0] TIME_LEFT;
  logic [1:0] LIVES;
  logic [3:0] CHECKPOINTS;
  logic       SEC_TICK;

  // Side that drives screen/events and consumes the outcome (screen FSM, bench)
  modport master (
    output SCREEN, COLLISION, CHECKPOINT,
    input  GAME_WIN, GAME_LOSE, TIME_LEFT, LIVES, CHECKPOINTS, SEC_TICK
  );

  // Rules engine side
  modport slave (
    input  SCREEN, COLLISION, CHECKPOINT,
    output GAME_WIN, GAME_LOSE, TIME_LEFT, LIVES, CHECKPOINTS, SEC_TICK
  );
endinterface

// File: rtl/race_outcome_ctrl.sv
// Race rules engine: while the race screen is shown it runs a seconds
// countdown, a lives counter with post-hit invulnerability and a checkpoint
// counter, and declares win (priority) or lose for the screen FSM.
module race_outcome_ctrl #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int RACE_SECONDS = 60,
  parameter int LIVES_INIT   = 3,
  parameter int CP_TO_WIN    = 5,
  parameter int INVULN_CYC   = 25_000_000
) (
  input logic               CLOCK_50,
  input logic               RESETN,
  race_outcome_ctrl_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(INVULN_CYC + 1);

  localparam logic [1:0]    SCR_RACE   = 2'b01;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [6:0]    TIME_INIT  = 7'(RACE_SECONDS);
  localparam logic [1:0]    LIVES_LD   = 2'(LIVES_INIT);
  localparam logic [3:0]    CP_WIN     = 4'(CP_TO_WIN);
  localparam logic [IW-1:0] INVULN_LD  = IW'(INVULN_CYC);

  typedef enum logic [1:0] {S_IDLE, S_RACING, S_WON, S_LOST} state_t;

  state_t        r_state;
  logic [6:0]    r_time;
  logic [1:0]    r_lives;
  logic [3:0]    r_cps;
  logic [PW-1:0] r_presc;
  logic [IW-1:0] r_invuln;
  logic          r_tick;
  logic          r_win;
  logic          r_lose;
  logic          r_col_prev;
  logic          r_cp_prev;

  state_t        w_state_next;
  logic [6:0]    w_time_next;
  logic [1:0]    w_lives_next;
  logic [3:0]    w_cps_next;
  logic [PW-1:0] w_presc_next;
  logic [IW-1:0] w_invuln_next;
  logic          w_tick_next;
  logic          w_col_edge;
  logic          w_cp_edge;
  logic          w_on_race;

  assign w_col_edge = bus.COLLISION  & ~r_col_prev;
  assign w_cp_edge  = bus.CHECKPOINT & ~r_cp_prev;
  assign w_on_race  = (bus.SCREEN == SCR_RACE);

  // Next-state and counter updates; every register holds unless changed below
  always_comb begin
    w_state_next  = r_state;
    w_time_next   = r_time;
    w_lives_next  = r_lives;
    w_cps_next    = r_cps;
    w_presc_next  = r_presc;
    w_invuln_next = r_invuln;
    w_tick_next   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_on_race) begin
          w_state_next  = S_RACING;
          w_time_next   = TIME_INIT;
          w_lives_next  = LIVES_LD;
          w_cps_next    = 4'd0;
          w_presc_next  = '0;
          w_invuln_next = '0;
        end
      end
      S_RACING: begin
        if (!w_on_race) begin
          // Leaving the race screen wins over any event this cycle
          w_state_next = S_IDLE;
        end else begin
          if (r_presc == PRESC_LAST) begin
            w_presc_next = '0;
            if (r_time != 7'd0) begin
              w_time_next = r_time - 7'd1;
              w_tick_next = 1'b1;
            end
          end else begin
            w_presc_next = r_presc + PW'(1);
          end
          if (w_cp_edge && (r_cps < CP_WIN)) begin
            w_cps_next = r_cps + 4'd1;
          end
          // Hits during the invulnerability window are dropped, not queued
          if (w_col_edge && (r_invuln == '0)) begin
            if (r_lives != 2'd0) begin
              w_lives_next = r_lives - 2'd1;
            end
            w_invuln_next = INVULN_LD;
          end else if (r_invuln != '0) begin
            w_invuln_next = r_invuln - IW'(1);
          end
          // Win is checked first so a simultaneous lose condition cannot mask it
          if (w_cp_edge && (w_cps_next == CP_WIN)) begin
            w_state_next = S_WON;
          end else if ((w_lives_next == 2'd0) || (w_time_next == 7'd0)) begin
            w_state_next = S_LOST;
          end
        end
      end
      S_WON, S_LOST: begin
        if (!w_on_race) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State, counters, registered outputs and input edge history
  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      r_state    <= S_IDLE;
      r_time     <= 7'd0;
      r_lives    <= 2'd0;
      r_cps      <= 4'd0;
      r_presc    <= '0;
      r_invuln   <= '0;
      r_tick     <= 1'b0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
      r_col_prev <= 1'b0;
      r_cp_prev  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_time     <= w_time_next;
      r_lives    <= w_lives_next;
      r_cps      <= w_cps_next;
      r_presc    <= w_presc_next;
      r_invuln   <= w_invuln_next;
      r_tick     <= w_tick_next;
      r_win      <= (w_state_next == S_WON);
      r_lose     <= (w_state_next == S_LOST);
      r_col_prev <= bus.COLLISION;
      r_cp_prev  <= bus.CHECKPOINT;
    end
  end

  assign bus.GAME_WIN    = r_win;
  assign bus.GAME_LOSE   = r_lose;
  assign bus.TIME_LEFT   = r_time;
  assign bus.LIVES       = r_lives;
  assign bus.CHECKPOINTS = r_cps;
  assign bus.SEC_TICK    = r_tick;

endmodule

// File: tb/tb_race_outcome_ctrl.sv
// Scoreboard bench for race_outcome_ctrl with a short race:
// 4 cycles per second, 3 seconds, 2 lives, 2 checkpoints, 5-cycle invulnerability.
module tb_race_outcome_ctrl;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  logic [15:0] exp_q[$];
  logic [15:0] obs;
  logic [15:0] e;

  race_outcome_ctrl_if bus();

  race_outcome_ctrl #(
    .TICK_DIV(4), .RACE_SECONDS(3), .LIVES_INIT(2), .CP_TO_WIN(2), .INVULN_CYC(5)
  ) dut (
    .CLOCK_50(clk),
    .RESETN(rstn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {bus.TIME_LEFT, bus.LIVES, bus.CHECKPOINTS, bus.SEC_TICK, bus.GAME_WIN, bus.GAME_LOSE};

  function automatic logic [15:0] pk(int t, int l, int c, bit tk, bit w, bit lo);
    return {7'(t), 2'(l), 4'(c), tk, w, lo};
  endfunction

  // Seconds left k cycles after the race was loaded (4 cycles per second)
  function automatic int tl_at(int k);
    return (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.SCREEN = 2'b00;
    bus.COLLISION = 1'b0;
    bus.CHECKPOINT = 1'b0;
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    step();
    step();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", obs, e);
    end else $display("reset obs=%h", obs);
    rstn = 1'b1;
    step();
  endtask

  task automatic test_countdown();
    for (int k = 0; k <= 16; k++) begin
      bus.SCREEN = (k < 16) ? 2'b01 : 2'b00;
      if (k < 16) exp_q.push_back(pk(tl_at(k), 2, 0, (k == 4 || k == 8 || k == 12), 0, (k >= 12)));
      else        exp_q.push_back(pk(0, 2, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL countdown k=%0d got=%h exp=%h tl=%0d", k, obs, e, bus.TIME_LEFT);
      end else $display("countdown k=%0d obs=%h", k, obs);
    end
  endtask

  task automatic test_checkpoint_win();
    for (int k = 0; k <= 6; k++) begin
      bus.SCREEN = (k < 6) ? 2'b01 : 2'b00;
      bus.CHECKPOINT = (k == 1 || k == 3);
      if (k == 0)      exp_q.push_back(pk(3, 2, 0, 0, 0, 0));
      else if (k < 3)  exp_q.push_back(pk(3, 2, 1, 0, 0, 0));
      else if (k < 6)  exp_q.push_back(pk(3, 2, 2, 0, 1, 0));
      else             exp_q.push_back(pk(3, 2, 2, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL checkpoint_win k=%0d got=%h exp=%h cp=%0d", k, obs, e, bus.CHECKPOINTS);
      end else $display("checkpoint_win k=%0d obs=%h", k, obs);
    end
    bus.CHECKPOINT = 1'b0;
  endtask

  task automatic test_collision_invuln();
    for (int k = 0; k <= 11; k++) begin
      bus.SCREEN = (k < 11) ? 2'b01 : 2'b00;
      bus.COLLISION = (k == 1 || k == 4 || k == 9);
      if (k == 0)      exp_q.push_back(pk(3, 2, 0, 0, 0, 0));
      else if (k < 9)  exp_q.push_back(pk(tl_at(k), 1, 0, (k == 4 || k == 8), 0, 0));
      else if (k < 11) exp_q.push_back(pk(1, 0, 0, 0, 0, 1));
      else             exp_q.push_back(pk(1, 0, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL collision_invuln k=%0d got=%h exp=%h lives=%0d", k, obs, e, bus.LIVES);
      end else $display("collision_invuln k=%0d obs=%h", k, obs);
    end
    bus.COLLISION = 1'b0;
  endtask

  task automatic test_collision_held();
    for (int k = 0; k <= 21; k++) begin
      bus.SCREEN = (k < 21) ? 2'b01 : 2'b00;
      bus.COLLISION = (k >= 1 && k <= 20);
      if (k == 0)      exp_q.push_back(pk(3, 2, 0, 0, 0, 0));
      else if (k < 21) exp_q.push_back(pk(tl_at(k), 1, 0, (k == 4 || k == 8 || k == 12), 0, (k >= 12)));
      else             exp_q.push_back(pk(0, 1, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL collision_held k=%0d got=%h exp=%h lives=%0d", k, obs, e, bus.LIVES);
      end else $display("collision_held k=%0d obs=%h", k, obs);
    end
    bus.COLLISION = 1'b0;
  endtask

  task automatic test_win_priority();
    // Final checkpoint together with the last-life collision
    for (int k = 0; k <= 10; k++) begin
      bus.SCREEN = (k < 10) ? 2'b01 : 2'b00;
      bus.CHECKPOINT = (k == 1 || k == 8);
      bus.COLLISION = (k == 2 || k == 8);
      if (k == 0)      exp_q.push_back(pk(3, 2, 0, 0, 0, 0));
      else if (k == 1) exp_q.push_back(pk(3, 2, 1, 0, 0, 0));
      else if (k < 8)  exp_q.push_back(pk(tl_at(k), 1, 1, (k == 4), 0, 0));
      else if (k == 8) exp_q.push_back(pk(1, 0, 2, 1, 1, 0));
      else if (k == 9) exp_q.push_back(pk(1, 0, 2, 0, 1, 0));
      else             exp_q.push_back(pk(1, 0, 2, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL win_vs_life k=%0d got=%h exp=%h w=%b l=%b", k, obs, e, bus.GAME_WIN, bus.GAME_LOSE);
      end else $display("win_vs_life k=%0d obs=%h", k, obs);
    end
    // Final checkpoint together with the last second expiring
    for (int k = 0; k <= 14; k++) begin
      bus.SCREEN = (k < 14) ? 2'b01 : 2'b00;
      bus.CHECKPOINT = (k == 1 || k == 12);
      bus.COLLISION = 1'b0;
      if (k == 0)       exp_q.push_back(pk(3, 2, 0, 0, 0, 0));
      else if (k < 12)  exp_q.push_back(pk(tl_at(k), 2, 1, (k == 4 || k == 8), 0, 0));
      else if (k == 12) exp_q.push_back(pk(0, 2, 2, 1, 1, 0));
      else if (k == 13) exp_q.push_back(pk(0, 2, 2, 0, 1, 0));
      else              exp_q.push_back(pk(0, 2, 2, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL win_vs_time k=%0d got=%h exp=%h w=%b l=%b", k, obs, e, bus.GAME_WIN, bus.GAME_LOSE);
      end else $display("win_vs_time k=%0d obs=%h", k, obs);
    end
    bus.CHECKPOINT = 1'b0;
  endtask

  task automatic test_abort_reset();
    // Abort at k=6 coincides with a checkpoint edge, which must be ignored
    for (int k = 0; k <= 8; k++) begin
      bus.SCREEN = (k == 6) ? 2'b00 : 2'b01;
      bus.CHECKPOINT = (k == 6);
      if (k == 0)      exp_q.push_back(pk(3, 2, 0, 0, 0, 0));
      else if (k < 6)  exp_q.push_back(pk(tl_at(k), 2, 0, (k == 4), 0, 0));
      else if (k == 6) exp_q.push_back(pk(2, 2, 0, 0, 0, 0));
      else             exp_q.push_back(pk(3, 2, 0, 0, 0, 0));
      step();
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL abort k=%0d got=%h exp=%h", k, obs, e);
      end else $display("abort k=%0d obs=%h", k, obs);
    end
    bus.CHECKPOINT = 1'b0;
    // Asynchronous reset between clock edges
    #2;
    rstn = 1'b0;
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    #1;
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", obs, e);
    end else $display("async_reset obs=%h", obs);
    bus.SCREEN = 2'b00;
    step();
    rstn = 1'b1;
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
    step();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL after_reset got=%h exp=%h", obs, e);
    end else $display("after_reset obs=%h", obs);
    // Re-entering the race after reset loads fresh values
    bus.SCREEN = 2'b01;
    exp_q.push_back(pk(3, 2, 0, 0, 0, 0));
    step();
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reload_after_reset got=%h exp=%h", obs, e);
    end else $display("reload_after_reset obs=%h", obs);
    bus.SCREEN = 2'b00;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_countdown();
    test_checkpoint_win();
    test_collision_invuln();
    test_collision_held();
    test_win_priority();
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
